// File: rtl/uart_frame_rx.sv
// UART frame receiver: 2-flop synchronized input, 3-sample majority per bit,
// single-entry output buffer with overrun/frame-error pulses.
module uart_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned MID      = CLKS_PER_BIT / 2;
  localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] SMP_A    = 16'(MID - 1);
  localparam logic [15:0] SMP_B    = 16'(MID);
  localparam logic [15:0] SMP_C    = 16'(MID + 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t               state;
  logic                 rx_q1, rx_s;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic [15:0]          cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0, smp1;
  logic                 maj, at_smp, at_wrap, deliver;

  assign maj     = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign at_smp  = (cnt == SMP_C);
  assign at_wrap = (cnt == CNT_LAST);
  assign deliver = (state == STOP) && at_smp && maj;
  assign busy    = (state != IDLE);

  // armed stays low after reset until a genuine (post-fill) high is seen on
  // rx_s, so the tail of a frame cut by reset is never taken as a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1     <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= '0;
      armed     <= 1'b0;
    end else begin
      rx_q1     <= rx;
      rx_s      <= rx_q1;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      smp0      <= 1'b0;
      smp1      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      cnt       <= at_wrap ? '0 : cnt + 16'd1;
      if (cnt == SMP_A) smp0 <= rx_s;
      if (cnt == SMP_B) smp1 <= rx_s;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (armed && !rx_s) state <= START;
        end
        START: begin
          if (at_smp && maj) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (at_wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (at_smp) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_idx == LAST_BIT) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (at_smp) begin
            cnt <= '0;
            if (maj) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Single-entry buffer: a same-cycle handshake frees the slot for the new byte.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
